// File: rtl/multi_step.sv
// multi_step: one platform step (regular, breakable or moving) drawn inside its tile.
// Define MULTI_STEP_RESPAWN_EN to make a vanished step reappear after RESPAWN_FRAMES frames.
module multi_step #(
   parameter int STEP_WIDTH_X       = 60,
   parameter int STEP_HEIGHT_Y      = 7,
   parameter int STEP_TILE_OFFSET_X = 2,
   parameter int STEP_TILE_OFFSET_Y = 50,
   parameter logic [7:0] COLOR_REGU  = 8'h5B,
   parameter logic [7:0] COLOR_BREAK = 8'hE0,
   parameter logic [7:0] COLOR_MOVE  = 8'h1F,
   parameter int BREAK_FRAMES       = 60,
   parameter int BLINK_LOG2         = 2,
   parameter int MOVE_RANGE         = 40,
   parameter int RESPAWN_FRAMES     = 120
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic [10:0] tileTopLeftX,
   input  logic [10:0] tileTopLeftY,
   input  logic [2:0]  step_type,
   input  logic        landed,
   output logic [10:0] offsetX,
   output logic [10:0] offsetY,
   output logic        drawingRequest,
   output logic [7:0]  RGBout,
   output logic        solid
);
   typedef enum logic [1:0] {SOLID, CRACKING, GONE} state_t;
   state_t state, state_n;
   logic [7:0] frame_cnt, frame_cnt_n, move_off, move_off_n;
   logic dir, dir_n;
   logic [2:0] prev_type;
   logic [1:0] t;
   logic [11:0] left, top, right, bottom, dx, dy;
   logic in_step, visible, draw;
   logic [7:0] color;
   assign t = step_type[2] ? 2'd0 : step_type[1:0];
   assign left = {1'b0, tileTopLeftX} + 12'(STEP_TILE_OFFSET_X) + {4'b0, move_off};
   assign top = {1'b0, tileTopLeftY} + 12'(STEP_TILE_OFFSET_Y);
   assign right = left + 12'(STEP_WIDTH_X);
   assign bottom = top + 12'(STEP_HEIGHT_Y);
   assign dx = {1'b0, pixelX} - left;
   assign dy = {1'b0, pixelY} - top;
   assign in_step = {1'b0, pixelX} >= left && {1'b0, pixelX} < right && {1'b0, pixelY} >= top && {1'b0, pixelY} < bottom;
   assign visible = t != 2'd0 && (state == SOLID || (state == CRACKING && !frame_cnt[BLINK_LOG2]));
   assign draw = in_step && visible;
   assign color = t == 2'd1 ? COLOR_REGU : t == 2'd2 ? COLOR_BREAK : COLOR_MOVE;
   always_comb begin
      state_n = state;
      frame_cnt_n = frame_cnt;
      move_off_n = move_off;
      dir_n = dir;
      if (step_type != prev_type) begin
         state_n = SOLID;
         frame_cnt_n = 8'd0;
         move_off_n = 8'd0;
         dir_n = 1'b0;
      end else begin
         if (state == SOLID && t == 2'd2 && landed) begin
            state_n = CRACKING;
            frame_cnt_n = 8'd0;
         end else if (state == CRACKING && startOfFrame) begin
            state_n = frame_cnt == 8'(BREAK_FRAMES - 1) ? GONE : CRACKING;
            frame_cnt_n = frame_cnt == 8'(BREAK_FRAMES - 1) ? 8'd0 : frame_cnt + 8'd1;
         end
`ifdef MULTI_STEP_RESPAWN_EN
         else if (state == GONE && startOfFrame) begin
            state_n = frame_cnt == 8'(RESPAWN_FRAMES - 1) ? SOLID : GONE;
            frame_cnt_n = frame_cnt == 8'(RESPAWN_FRAMES - 1) ? 8'd0 : frame_cnt + 8'd1;
         end
`endif
         // dir=1 means travelling left; flip exactly on reaching either end
         if (t == 2'd3 && startOfFrame) begin
            move_off_n = dir ? move_off - 8'd1 : move_off + 8'd1;
            dir_n = move_off_n == 8'(MOVE_RANGE) ? 1'b1 : move_off_n == 8'd0 ? 1'b0 : dir;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state <= SOLID;
         frame_cnt <= 8'd0;
         move_off <= 8'd0;
         dir <= 1'b0;
         prev_type <= step_type;
         drawingRequest <= 1'b0;
         RGBout <= 8'hFF;
         offsetX <= 11'd0;
         offsetY <= 11'd0;
         solid <= 1'b0;
      end else begin
         state <= state_n;
         frame_cnt <= frame_cnt_n;
         move_off <= move_off_n;
         dir <= dir_n;
         prev_type <= step_type;
         drawingRequest <= draw;
         RGBout <= draw ? color : 8'hFF;
         offsetX <= draw ? dx[10:0] : 11'd0;
         offsetY <= draw ? dy[10:0] : 11'd0;
         solid <= t != 2'd0 && state_n != GONE;
      end
   end
endmodule

// File: tb/tb_multi_step.sv
// tb_multi_step: scoreboard bench for multi_step; honours MULTI_STEP_RESPAWN_EN.
module tb_multi_step;
   logic clk = 1'b0, resetN, startOfFrame, landed;
   logic [10:0] pixelX, pixelY, tileTopLeftX, tileTopLeftY, offsetX, offsetY;
   logic [2:0] step_type;
   logic drawingRequest, solid;
   logic [7:0] RGBout;
   typedef struct packed {logic dr; logic [7:0] rgb; logic [10:0] ox; logic [10:0] oy; logic sol;} exp_t;
   exp_t sb[$];
   logic probe_v = 1'b0, pend = 1'b0;
   int total = 0, bad = 0, id = 0;
   multi_step dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pixelX(pixelX), .pixelY(pixelY),
      .tileTopLeftX(tileTopLeftX), .tileTopLeftY(tileTopLeftY), .step_type(step_type), .landed(landed),
      .offsetX(offsetX), .offsetY(offsetY), .drawingRequest(drawingRequest), .RGBout(RGBout), .solid(solid)
   );
   always #5 clk = ~clk;
   always @(posedge clk) pend <= probe_v;
   always @(negedge clk) begin
      exp_t e, got;
      if (pend) begin
         total++;
         id++;
         got = {drawingRequest, RGBout, offsetX, offsetY, solid};
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL chk%0d: output with empty scoreboard", id);
         end else begin
            e = sb.pop_front();
            if (got !== e) begin
               bad++;
               $display("FAIL chk%0d: got dr=%b rgb=%h off=(%0d,%0d) solid=%b need dr=%b rgb=%h off=(%0d,%0d) solid=%b",
                  id, got.dr, got.rgb, got.ox, got.oy, got.sol, e.dr, e.rgb, e.ox, e.oy, e.sol);
            end
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic frame();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
   endtask
   task automatic probe(input logic [10:0] px, input logic [10:0] py, input logic dr, input logic [7:0] rgb,
                        input logic [10:0] ox, input logic [10:0] oy, input logic sol);
      pixelX = px;
      pixelY = py;
      sb.push_back({dr, rgb, ox, oy, sol});
      probe_v = 1'b1;
      tick();
      probe_v = 1'b0;
   endtask
   task automatic miss(input logic [10:0] px, input logic [10:0] py, input logic sol);
      probe(px, py, 1'b0, 8'hFF, 11'd0, 11'd0, sol);
   endtask
   initial begin
      resetN = 1'b0; startOfFrame = 1'b0; landed = 1'b0; step_type = 3'd1;
      tileTopLeftX = 11'd100; tileTopLeftY = 11'd40; pixelX = 11'd0; pixelY = 11'd0;
      miss(102, 90, 0);
      resetN = 1'b1;
      probe(102, 90, 1, 8'h5B, 0, 0, 1);
      miss(162, 90, 1);
      probe(161, 96, 1, 8'h5B, 59, 6, 1);
      miss(101, 90, 1);
      miss(102, 97, 1);
      step_type = 3'd0; miss(110, 92, 0);
      step_type = 3'd5; miss(110, 92, 0);
      step_type = 3'd2; probe(110, 92, 1, 8'hE0, 8, 2, 1);
      landed = 1'b1; probe(110, 92, 1, 8'hE0, 8, 2, 1); landed = 1'b0;
      for (int f = 0; f < 60; f++) begin
         if ((f & 4) == 0) probe(110, 92, 1, 8'hE0, 8, 2, 1);
         else miss(110, 92, 1);
         frame();
      end
      miss(110, 92, 0);
      landed = 1'b1; miss(110, 92, 0); landed = 1'b0;
`ifdef MULTI_STEP_RESPAWN_EN
      repeat (119) frame();
      miss(110, 92, 0);
      frame();
      probe(110, 92, 1, 8'hE0, 8, 2, 1);
`else
      repeat (300) frame();
      miss(110, 92, 0);
`endif
      step_type = 3'd1; tick();
      step_type = 3'd2; probe(110, 92, 1, 8'hE0, 8, 2, 1);
      landed = 1'b1; startOfFrame = 1'b1; probe(110, 92, 1, 8'hE0, 8, 2, 1); landed = 1'b0; startOfFrame = 1'b0;
      probe(110, 92, 1, 8'hE0, 8, 2, 1);
      repeat (3) frame();
      probe(110, 92, 1, 8'hE0, 8, 2, 1);
      frame();
      miss(110, 92, 1);
      step_type = 3'd1; miss(110, 92, 1);
      probe(110, 92, 1, 8'h5B, 8, 2, 1);
      repeat (4) frame();
      probe(110, 92, 1, 8'h5B, 8, 2, 1);
      step_type = 3'd2; probe(110, 92, 1, 8'hE0, 8, 2, 1);
      landed = 1'b1; probe(110, 92, 1, 8'hE0, 8, 2, 1); landed = 1'b0;
      repeat (4) frame();
      miss(110, 92, 1);
      resetN = 1'b0; miss(110, 92, 0); resetN = 1'b1;
      probe(110, 92, 1, 8'hE0, 8, 2, 1);
      repeat (4) frame();
      probe(110, 92, 1, 8'hE0, 8, 2, 1);
      step_type = 3'd3; probe(102, 90, 1, 8'h1F, 0, 0, 1);
      repeat (10) frame();
      probe(112, 90, 1, 8'h1F, 0, 0, 1);
      miss(111, 90, 1);
      repeat (30) frame();
      probe(142, 90, 1, 8'h1F, 0, 0, 1);
      miss(141, 90, 1);
      repeat (5) frame();
      probe(137, 90, 1, 8'h1F, 0, 0, 1);
      miss(136, 90, 1);
      probe(196, 96, 1, 8'h1F, 59, 6, 1);
      miss(197, 90, 1);
      repeat (3) tick();
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expected outputs never appeared, need 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multi_step.md
MULTI_STEP -- requirements
Module: multi_step

Interface
REQ-001 The module SHALL have parameter STEP_WIDTH_X, default 60, meaning step width in pixels.
REQ-002 The module SHALL have parameter STEP_HEIGHT_Y, default 7, meaning step height in pixels.
REQ-003 The module SHALL have parameters STEP_TILE_OFFSET_X and STEP_TILE_OFFSET_Y, defaults 2 and 50, meaning the step's top-left offset inside its tile.
REQ-004 The module SHALL have parameters COLOR_REGU, COLOR_BREAK and COLOR_MOVE, defaults 8'h5B, 8'hE0 and 8'h1F, meaning the fill colour per step type.
REQ-005 The module SHALL have parameter BREAK_FRAMES, default 60, range 1-255, meaning the number of frames spent cracking before the step disappears.
REQ-006 The module SHALL have parameter BLINK_LOG2, default 2, range 0-6, meaning the log2 of the blink half-period in frames.
REQ-007 The module SHALL have parameter MOVE_RANGE, default 40, range 1-255, meaning the horizontal travel of a moving step in pixels.
REQ-008 The module SHALL have parameter RESPAWN_FRAMES, default 120, range 1-255, meaning the number of frames a gone step stays absent.
REQ-009 Port clk SHALL be an input, 1 bit, the single system clock; all logic SHALL be clocked on its rising edge.
REQ-010 Port resetN SHALL be an input, 1 bit, a synchronous active-low reset.
REQ-011 Port startOfFrame SHALL be an input, 1 bit, pulsed high for one clk cycle per video frame.
REQ-012 Ports pixelX and pixelY SHALL be inputs, 11 bits each, carrying the current VGA pixel.
REQ-013 Ports tileTopLeftX and tileTopLeftY SHALL be inputs, 11 bits each, carrying the tile position in the grid.
REQ-014 Port step_type SHALL be an input, 3 bits, encoded FREE=0, REGU=1, BREAK=2, MOVE=3; values 4-7 SHALL be treated as FREE.
REQ-015 Port landed SHALL be an input, 1 bit, indicating that the player touched this step in the current cycle.
REQ-016 Ports offsetX and offsetY SHALL be outputs, 11 bits each, giving the pixel offset from the step's top-left corner.
REQ-017 Port drawingRequest SHALL be an output, 1 bit, asserted when the step is drawing the current pixel.
REQ-018 Port RGBout SHALL be an output, 8 bits, carrying the pixel colour.
REQ-019 Port solid SHALL be an output, 1 bit, high when the step can currently support the player.

Function
REQ-020 The step's bounds SHALL be computed as left = tileTopLeftX + STEP_TILE_OFFSET_X + moveOff, top = tileTopLeftY + STEP_TILE_OFFSET_Y, with right = left + STEP_WIDTH_X and bottom = top + STEP_HEIGHT_Y, evaluated at 12-bit width with no wrap-around.
REQ-021 A pixel SHALL be inside the step when left <= pixelX < right and top <= pixelY < bottom.
REQ-022 Outputs SHALL be registered, appearing exactly 1 clk after the corresponding pixelX/pixelY inputs.
REQ-023 When a pixel is drawn: drawingRequest=1, RGBout = the type colour, offsetX = pixelX - left, offsetY = pixelY - top.
REQ-024 When a pixel is not drawn: drawingRequest=0, RGBout=8'hFF, offsetX=0, offsetY=0.
REQ-025 The state machine SHALL have the states SOLID, CRACKING and GONE; the 8-bit frame counter frameCnt SHALL advance only on startOfFrame.
REQ-026 In SOLID with step_type=BREAK and landed=1, the FSM SHALL enter CRACKING on the next clk with frameCnt=0.
REQ-027 CRACKING SHALL draw only while frameCnt[BLINK_LOG2]=0.
REQ-028 CRACKING SHALL move to GONE, with frameCnt=0, on the startOfFrame for which frameCnt = BREAK_FRAMES-1.
REQ-029 GONE SHALL never draw.
REQ-030 In CRACKING and GONE, landed SHALL be ignored.
REQ-031 solid SHALL be 1 in SOLID and CRACKING for REGU, BREAK and MOVE types, and 0 otherwise.
REQ-032 For MOVE, the 8-bit moveOff SHALL step by 1 on each startOfFrame in direction dir.
REQ-033 The direction dir SHALL flip to left when moveOff reaches MOVE_RANGE and flip to right when moveOff reaches 0, so the bounds are never exceeded.
REQ-034 For all types other than MOVE, moveOff SHALL be 0.
REQ-035 FREE SHALL never draw, and solid SHALL be 0.
REQ-036 Any change of step_type between clocks SHALL force SOLID, frameCnt=0, moveOff=0 and dir=right on the next clk, with priority over landed.
REQ-037 When landed and startOfFrame occur in the same cycle in SOLID, the FSM SHALL take the SOLID->CRACKING transition and SHALL NOT advance frameCnt.

Reset
REQ-038 When resetN=0 at a rising clk, the block SHALL set: state=SOLID, frameCnt=0, moveOff=0, dir=right, drawingRequest=0, RGBout=8'hFF, offsetX=0, offsetY=0, solid=0.
REQ-039 A reset asserted mid-CRACKING or mid-GONE SHALL take priority over all other inputs.

Configuration
REQ-040 The macro MULTI_STEP_RESPAWN_EN SHALL control respawn behaviour.
REQ-041 With MULTI_STEP_RESPAWN_EN defined, GONE SHALL return to SOLID, with frameCnt=0, on the startOfFrame for which frameCnt = RESPAWN_FRAMES-1.
REQ-042 Without MULTI_STEP_RESPAWN_EN, GONE SHALL be terminal until reset or a step_type change, and RESPAWN_FRAMES SHALL be unused.

Verification
REQ-043 REGU, tile (100,40), pixel (102,90) -> after 1 clk drawingRequest=1, RGBout=8'h5B, offset=(0,0); pixel (162,90) -> drawingRequest=0, RGBout=8'hFF.
REQ-044 BREAK, landed pulse, then 60 frames -> drawn in frames 0-3, blank in 4-7, alternating; GONE after the 60th startOfFrame; solid=0.
REQ-045 MOVE, 45 frames -> moveOff reaches 40 at frame 40 and reads 35 at frame 45; step left edge at tile+2+moveOff.
REQ-046 With MULTI_STEP_RESPAWN_EN, a GONE step returns to SOLID after 120 frames; without it, the step is still GONE after 300 frames.
REQ-047 Mid-CRACKING: step_type changed to REGU -> SOLID next clk; resetN=0 -> all reset values next clk.
REQ-048 landed and startOfFrame in the same cycle -> CRACKING with frameCnt=0.
